// File: rtl/display_scan_ctrl_if.sv
// display_scan_ctrl_if: image write handshake between a writer and the scan controller
interface display_scan_ctrl_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_hex;
    logic [3:0]  wr_point;
    logic [3:0]  wr_blink;
    modport master(output wr_valid, wr_hex, wr_point, wr_blink, input wr_ready);
    modport slave(input wr_valid, wr_hex, wr_point, wr_blink, output wr_ready);
endinterface

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: 4-digit multiplexed display scanner with frame-synchronous image commit and blink
module display_scan_ctrl #(
    parameter int DIV          = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    display_scan_ctrl_if.slave   wr,
    output logic [1:0]           scan,
    output logic [15:0]          disp_hex,
    output logic [3:0]           disp_point,
    output logic [3:0]           disp_le,
    output logic                 frame_done
);
    localparam int PW = $clog2(DIV);
    localparam int FW = $clog2(BLINK_FRAMES + 1);
    localparam logic [PW-1:0] P_MAX = PW'(DIV - 1);
    localparam logic [FW-1:0] F_MAX = FW'(BLINK_FRAMES - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    scan_q, scan_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          phase_q, phase_d;
    logic          pend_q, pend_d;
    logic [15:0]   p_hex_q, p_hex_d, hex_q, hex_d;
    logic [3:0]    p_pt_q, p_pt_d, pt_q, pt_d;
    logic [3:0]    p_bl_q, p_bl_d, bl_q, bl_d;
    logic [3:0]    le_q, le_d;
    logic          fd_q, fd_d;
    logic          tick, fb, accept, commit;

    // Next state: prescaler/scan/frame timing, pending buffer handshake, commit at frame boundary.
    // Accept needs an empty buffer and commit needs a full one, so they never collide.
    always_comb begin
        tick     = presc_q == P_MAX;
        fb       = tick && scan_q == 2'd3;
        accept   = wr.wr_valid && !pend_q;
        commit   = fb && pend_q;
        presc_d  = tick ? '0 : presc_q + 1'b1;
        scan_d   = scan_q + {1'b0, tick};
        fcnt_d   = fb ? (fcnt_q == F_MAX ? '0 : fcnt_q + 1'b1) : fcnt_q;
        phase_d  = phase_q ^ (fb && fcnt_q == F_MAX);
        pend_d   = accept | (pend_q & ~fb);
        p_hex_d  = accept ? wr.wr_hex : p_hex_q;
        p_pt_d   = accept ? wr.wr_point : p_pt_q;
        p_bl_d   = accept ? wr.wr_blink : p_bl_q;
        hex_d    = commit ? p_hex_q : hex_q;
        pt_d     = commit ? p_pt_q : pt_q;
        bl_d     = commit ? p_bl_q : bl_q;
        le_d     = bl_q & {4{phase_q}};
        fd_d     = fb;
    end

    // State registers; reset discards any pending image.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            scan_q  <= '0;
            fcnt_q  <= '0;
            phase_q <= 1'b0;
            pend_q  <= 1'b0;
            p_hex_q <= '0;
            p_pt_q  <= '0;
            p_bl_q  <= '0;
            hex_q   <= '0;
            pt_q    <= '0;
            bl_q    <= '0;
            le_q    <= '0;
            fd_q    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            scan_q  <= scan_d;
            fcnt_q  <= fcnt_d;
            phase_q <= phase_d;
            pend_q  <= pend_d;
            p_hex_q <= p_hex_d;
            p_pt_q  <= p_pt_d;
            p_bl_q  <= p_bl_d;
            hex_q   <= hex_d;
            pt_q    <= pt_d;
            bl_q    <= bl_d;
            le_q    <= le_d;
            fd_q    <= fd_d;
        end
    end

    assign wr.wr_ready = !pend_q;
    assign scan        = scan_q;
    assign disp_hex    = hex_q;
    assign disp_point  = pt_q;
    assign disp_le     = le_q;
    assign frame_done  = fd_q;
endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter DIV, default 50000, clk cycles per digit slot; legal range 2..2^20.
REQ-002 Parameter BLINK_FRAMES, default 64, full frames per blink half-period; legal range 1..2^16.
REQ-003 Port clk  in  1  sole clock; all state changes on rising edge.
REQ-004 Port rst  in  1  reset, asynchronous, active-high.
REQ-005 Port wr_valid  in  1  writer offers a new display image.
REQ-006 Port wr_ready  out  1  controller can accept an image.
REQ-007 Port wr_hex  in  16  four 4-bit digit codes; digit i = bits [4i+3:4i].
REQ-008 Port wr_point  in  4  decimal-point enable per digit.
REQ-009 Port wr_blink  in  4  blink enable per digit.
REQ-010 Port scan  out  2  active digit index, drives the display mux/decoder select.
REQ-011 Port disp_hex  out  16  committed digit codes.
REQ-012 Port disp_point  out  4  committed decimal points.
REQ-013 Port disp_le  out  4  per-digit blank mask; bit i = 1 blanks digit i.
REQ-014 Port frame_done  out  1  one-cycle pulse at each frame boundary.

Function
REQ-015 Prescaler counts 0..DIV-1, wraps to 0; tick asserted on the cycle prescaler = DIV-1.
REQ-016 On tick, scan increments modulo 4 (3 -> 0); otherwise scan holds.
REQ-017 Frame boundary = tick while scan = 3; frame_done = 1 exactly on that cycle, registered, 0 otherwise.
REQ-018 One pending buffer (hex, point, blink) plus flag pend_full; wr_ready = NOT pend_full.
REQ-019 Handshake: wr_valid AND wr_ready at an edge loads pending buffer and sets pend_full; wr_valid while wr_ready = 0 is ignored, no data change.
REQ-020 At a frame boundary with pend_full = 1: disp_hex, disp_point, blink register take pending contents; pend_full clears same edge.
REQ-021 Committed outputs change only at frame boundaries; never mid-frame.
REQ-022 Handshake and frame boundary on the same edge with pend_full = 0: data captured into pending; commit at the next boundary, not this one.
REQ-023 Commit and new handshake cannot coincide (wr_ready = 0 while pend_full = 1); wr_ready returns 1 the cycle after commit.
REQ-024 Frame counter 0..BLINK_FRAMES-1 advances at each frame boundary; on wrap, blink_phase toggles.
REQ-025 disp_le = blink_reg AND {4{blink_phase}}, registered, updated the cycle after blink_reg or blink_phase changes.
REQ-026 Digits with blink bit 0 are never blanked; all outputs driven every cycle, no X after reset.

Reset
REQ-027 rst = 1 asynchronously forces: prescaler 0, scan 0, frame counter 0, blink_phase 0, pend_full 0, pending buffer 0, disp_hex 0, disp_point 0, blink_reg 0, disp_le 0, frame_done 0; wr_ready = 1.
REQ-028 Reset asserted mid-frame or with pend_full = 1 discards the pending image; no commit after release.
REQ-029 After rst release, first tick occurs DIV cycles later; first frame_done 4*DIV cycles later.

Verification (DIV = 4, BLINK_FRAMES = 2)
REQ-030 Reset release, no writes -> scan 0,1,2,3,0 changing every 4 clk; frame_done pulse at cycle 16, 32; disp_* remain 0.
REQ-031 Write wr_hex 0x1234, point 0x2, blink 0x0 at cycle 3 -> wr_ready 0 from cycle 4; disp_hex = 0x1234, disp_point = 0x2 the cycle after frame_done at 16; wr_ready 1 again.
REQ-032 Write image A then hold wr_valid with image B while pend_full -> B ignored until A commits; B accepted the cycle wr_ready rises; B commits at following boundary.
REQ-033 Handshake on exact frame-boundary cycle with pend_full = 0 -> no commit at that boundary; commit at boundary 16 cycles later.
REQ-034 Commit blink 0x5 -> disp_le toggles 0x0/0x5 every 2 frames (32 clk); digits 1 and 3 never blanked.
REQ-035 Assert rst with pend_full = 1 at cycle 10 -> all outputs 0 immediately, wr_ready 1, no later commit of the discarded image.
